sprite_blitter_gen: RTL and testbench
=====================================

Name: sprite_blitter_gen

Overview:
Parametrised sprite/clear engine writing a word-organised monochrome framebuffer through one synchronous BRAM port. Sprite rows are fetched from CPU memory through one synchronous read port. Next-generation drawing engine for the Chip8 display path: configurable word width and screen size, 8-wide and 16x16 sprites, per-command wrap/clip, XOR collision reporting, and full-screen clear. Sits between the CPU (command issuer) and the dual-port framebuffer shared with the VGA reader.

Parameters:
WORD_W, 16, framebuffer word width in pixels; power of 2, >=16; MSB = leftmost pixel.
SCREEN_W, 128, screen width in pixels; multiple of WORD_W, >= 2*WORD_W.
SCREEN_H, 64, screen height in rows; power of 2.
CPU_ADDR_W, 12, CPU memory address width.
Derived localparams: WPR = SCREEN_W/WORD_W; FB_WORDS = WPR*SCREEN_H; X_W = clog2(SCREEN_W); Y_W = clog2(SCREEN_H); FB_ADDR_W = clog2(FB_WORDS).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
start  in  1  command strobe; accepted only when ready=1
op  in  1  0 = SPRITE, 1 = CLEAR
src  in  CPU_ADDR_W  sprite data start address
height  in  4  rows 1..15 (8-wide); 0 = 16x16 sprite, 2 bytes/row, high byte first
dest_x  in  X_W  left pixel column
dest_y  in  Y_W  top row
clip  in  1  1 = drop pixels past right/bottom edge; 0 = wrap modulo screen
ready  out  1  idle, can accept a command
collision  out  1  some set sprite pixel hit a set framebuffer pixel during the last sprite
fb_addr  out  FB_ADDR_W  framebuffer word address (row-major, y*WPR + x/WORD_W)
fb_wdata  out  WORD_W  write data
fb_rdata  in  WORD_W  read data, valid 1 cycle after fb_en with fb_we=0
fb_en  out  1  port enable
fb_we  out  1  write enable
mem_addr  out  CPU_ADDR_W  sprite byte address
mem_rdata  in  8  byte, valid 1 cycle after mem_addr

Behaviour:
- Reset (async, any state): ready=1, collision=0, fb_en=0, fb_we=0, fb_addr=0, fb_wdata=0, mem_addr=0; state IDLE; partial command abandoned.
- Accept: start & ready in IDLE. All inputs latched; ready=0 the next cycle. start while ready=0 is ignored. At accept, collision clears to 0 for SPRITE and for CLEAR.
- States: IDLE, FETCH_HI, FETCH_LO (16-wide only), RD0, RD1, WR0, WR1, CLR, DONE.
- SPRITE row, fixed timing (5 cycles for 8-wide, 6 for 16-wide):
  - FETCH issues mem_addr.
  - RD0 latches the pattern and reads word0.
  - RD1 latches word0 and reads word1.
  - WR0 latches word1 and writes word0 ^ mask0.
  - WR1 writes word1 ^ mask1.
- Word1 read/write is suppressed (fb_en=0) when the row fits in word0 ((x mod WORD_W) + P <= WORD_W) or word1 is clipped. Timing is unchanged.
- Alignment: pattern P (8 or 16 bits) right-shifted by x mod WORD_W into a 2*WORD_W field split into mask0/mask1.
- Word index: word1 = (x/WORD_W + 1) mod WPR when clip=0. When clip=1 and x/WORD_W = WPR-1, mask1 is forced to 0.
- Row y: (dest_y + r) mod SCREEN_H when clip=0. When clip=1, rows with dest_y + r >= SCREEN_H are skipped entirely: no fetch, zero cycles.
- Collision: OR over rows of |(old_word & mask) for written words only.
- src address increments 1 per byte and wraps modulo 2^CPU_ADDR_W.
- CLR: writes 0 to addresses 0..FB_WORDS-1, one per cycle, ascending.
- DONE: 1 cycle, then ready=1. Busy duration: SPRITE = rows_drawn*(5 or 6)+1 cycles; CLEAR = FB_WORDS+1.
- collision is held stable from ready rising until the next accept.

Decomposition:
- Shared header blitter.vh: op codes (BLIT_OP_SPRITE=0, BLIT_OP_CLEAR=1) and state encodings.
- Sub-module sprite_row_shifter: purely combinational.
  - Inputs: pattern, wide flag, x mod WORD_W, clip, last-word flag.
  - Outputs: mask0, mask1, need_word1.
  - Unit-testable in isolation.

Test Plan:
- Params 16/128/64. Reset → ready=1, collision=0, fb_en=0, fb_we=0. Assert rst_n low mid-sprite → same values immediately, no further fb_we.
- Empty fb; SPRITE x=0, y=0, h=1, byte 0xF0 → word0=0xF000, collision=0, ready high 6 cycles after accept. Repeat the same command → word0=0x0000, collision=1.
- SPRITE x=12, y=3, h=1, byte 0xFF → word24=0x000F, word25=0xF000, all other words unchanged.
- SPRITE x=124, y=63, h=2, bytes 0xFF,0xFF, clip=0 → words 511=0x000F, 504=0xF000, 7=0x000F, 0=0xF000. Same with clip=1 → only word511=0x000F; busy 6 cycles.
- h=0, x=8, y=0, 16 bytes pairs 0xFFFF → words 8r=0x00FF and 8r+1=0xFF00 for r=0..15; busy 97 cycles.
- CLEAR on a filled fb → 512 ascending zero writes, ready after 513 cycles; start pulses while busy ignored; collision=0.

Source files
------------

// File: rtl/sprite_blitter_gen_pkg.sv
// Shared definitions for the sprite/clear blitter: op codes, FSM encodings, row-count helper.
package sprite_blitter_gen_pkg;

  localparam logic BLIT_OP_SPRITE = 1'b0;
  localparam logic BLIT_OP_CLEAR  = 1'b1;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH_HI = 4'd1;
  localparam logic [3:0] ST_FETCH_LO = 4'd2;
  localparam logic [3:0] ST_RD0      = 4'd3;
  localparam logic [3:0] ST_RD1      = 4'd4;
  localparam logic [3:0] ST_WR0      = 4'd5;
  localparam logic [3:0] ST_WR1      = 4'd6;
  localparam logic [3:0] ST_CLR      = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;

  // height 0 selects the 16x16 sprite
  function automatic logic [4:0] sprite_rows(input logic [3:0] h);
    return (h == 4'd0) ? 5'd16 : {1'b0, h};
  endfunction

endpackage

// File: rtl/sprite_row_shifter.sv
// Aligns one sprite row pattern onto a two-word framebuffer span; purely combinational.
module sprite_row_shifter #(
  parameter  int WORD_W = 16,
  localparam int OFF_W  = $clog2(WORD_W)
) (
  input  logic [15:0]       pattern,
  input  logic              wide,
  input  logic [OFF_W-1:0]  x_off,
  input  logic              clip,
  input  logic              last_word,
  output logic [WORD_W-1:0] mask0,
  output logic [WORD_W-1:0] mask1,
  output logic              need_word1
);

  logic [2*WORD_W-1:0] field;
  logic [OFF_W:0]      span;
  logic                drop1;

  always_comb begin
    field = '0;
    if (wide) field[2*WORD_W-1 -: 16] = pattern;
    else      field[2*WORD_W-1 -: 8]  = pattern[7:0];
    field = field >> x_off;
    drop1 = clip && last_word;
    span = {1'b0, x_off} + (wide ? (OFF_W+1)'(16) : (OFF_W+1)'(8));
    need_word1 = (span > (OFF_W+1)'(WORD_W)) && !drop1;
    mask0 = field[2*WORD_W-1:WORD_W];
    mask1 = drop1 ? '0 : field[WORD_W-1:0];
  end

endmodule

// File: rtl/sprite_blitter_gen.sv
// Sprite XOR-draw / full-screen clear engine on a word-organised monochrome framebuffer port.
module sprite_blitter_gen
  import sprite_blitter_gen_pkg::*;
#(
  parameter  int WORD_W     = 16,
  parameter  int SCREEN_W   = 128,
  parameter  int SCREEN_H   = 64,
  parameter  int CPU_ADDR_W = 12,
  localparam int WPR        = SCREEN_W / WORD_W,
  localparam int FB_WORDS   = WPR * SCREEN_H,
  localparam int X_W        = $clog2(SCREEN_W),
  localparam int Y_W        = $clog2(SCREEN_H),
  localparam int FB_ADDR_W  = $clog2(FB_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  op,
  input  logic [CPU_ADDR_W-1:0] src,
  input  logic [3:0]            height,
  input  logic [X_W-1:0]        dest_x,
  input  logic [Y_W-1:0]        dest_y,
  input  logic                  clip,
  output logic                  ready,
  output logic                  collision,
  output logic [FB_ADDR_W-1:0]  fb_addr,
  output logic [WORD_W-1:0]     fb_wdata,
  input  logic [WORD_W-1:0]     fb_rdata,
  output logic                  fb_en,
  output logic                  fb_we,
  output logic [CPU_ADDR_W-1:0] mem_addr,
  input  logic [7:0]            mem_rdata
);

  localparam int OFF_W = $clog2(WORD_W);
  localparam int XW_W  = X_W - OFF_W;

  logic [3:0]            state_q, state_d;
  logic                  wide_q, wide_d, clip_q, clip_d, coll_q, coll_d;
  logic [X_W-1:0]        x_q, x_d;
  logic [Y_W-1:0]        y_q, y_d;
  logic [4:0]            nrows_q, nrows_d, row_q, row_d;
  logic [CPU_ADDR_W-1:0] ptr_q, ptr_d;
  logic [15:0]           pat_q, pat_d;
  logic [WORD_W-1:0]     word0_q, word0_d, word1_q, word1_d;
  logic [FB_ADDR_W-1:0]  clr_q, clr_d;

  logic [XW_W-1:0]      xw, word1_idx;
  logic                 last_word, need1, more;
  logic [Y_W-1:0]       row_y;
  logic [FB_ADDR_W-1:0] row_base, addr0, addr1;
  logic [WORD_W-1:0]    mask0, mask1;
  logic [4:0]           next_row;
  logic [Y_W+5:0]       ysum;

  assign xw        = x_q[X_W-1:OFF_W];
  assign last_word = (xw == XW_W'(WPR - 1));
  assign word1_idx = last_word ? '0 : xw + XW_W'(1);
  assign row_y     = y_q + Y_W'(row_q);
  assign row_base  = FB_ADDR_W'(row_y) * FB_ADDR_W'(WPR);
  assign addr0     = row_base + FB_ADDR_W'(xw);
  assign addr1     = row_base + FB_ADDR_W'(word1_idx);
  assign next_row  = row_q + 5'd1;
  // Rows below the screen in clip mode are never fetched, so the row loop simply ends there.
  assign ysum      = (Y_W+6)'(y_q) + (Y_W+6)'(next_row);
  assign more      = (next_row < nrows_q) && !(clip_q && (ysum >= (Y_W+6)'(SCREEN_H)));
  assign collision = coll_q;

  sprite_row_shifter #(.WORD_W(WORD_W)) u_shifter (
    .pattern    (pat_q),
    .wide       (wide_q),
    .x_off      (x_q[OFF_W-1:0]),
    .clip       (clip_q),
    .last_word  (last_word),
    .mask0      (mask0),
    .mask1      (mask1),
    .need_word1 (need1)
  );

  always_comb begin
    state_d = state_q;
    wide_d  = wide_q;
    clip_d  = clip_q;
    coll_d  = coll_q;
    x_d     = x_q;
    y_d     = y_q;
    nrows_d = nrows_q;
    row_d   = row_q;
    ptr_d   = ptr_q;
    pat_d   = pat_q;
    word0_d = word0_q;
    word1_d = word1_q;
    clr_d   = clr_q;
    case (state_q)
      ST_IDLE: if (start) begin
        wide_d  = (height == 4'd0);
        clip_d  = clip;
        x_d     = dest_x;
        y_d     = dest_y;
        nrows_d = sprite_rows(height);
        row_d   = '0;
        ptr_d   = src;
        coll_d  = 1'b0;
        clr_d   = '0;
        state_d = (op == BLIT_OP_CLEAR) ? ST_CLR : ST_FETCH_HI;
      end
      ST_FETCH_HI: begin
        ptr_d   = ptr_q + CPU_ADDR_W'(1);
        state_d = wide_q ? ST_FETCH_LO : ST_RD0;
      end
      ST_FETCH_LO: begin
        ptr_d       = ptr_q + CPU_ADDR_W'(1);
        pat_d[15:8] = mem_rdata;
        state_d     = ST_RD0;
      end
      ST_RD0: begin
        pat_d[7:0] = mem_rdata;
        state_d    = ST_RD1;
      end
      ST_RD1: begin
        word0_d = fb_rdata;
        state_d = ST_WR0;
      end
      ST_WR0: begin
        word1_d = fb_rdata;
        coll_d  = coll_q | (|(word0_q & mask0));
        state_d = ST_WR1;
      end
      ST_WR1: begin
        if (need1) coll_d = coll_q | (|(word1_q & mask1));
        row_d   = next_row;
        state_d = more ? ST_FETCH_HI : ST_DONE;
      end
      ST_CLR: begin
        clr_d = clr_q + FB_ADDR_W'(1);
        if (clr_q == FB_ADDR_W'(FB_WORDS - 1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state_q == ST_IDLE);
    fb_en    = 1'b0;
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    mem_addr = '0;
    case (state_q)
      ST_FETCH_HI, ST_FETCH_LO: mem_addr = ptr_q;
      ST_RD0: begin
        fb_en   = 1'b1;
        fb_addr = addr0;
      end
      ST_RD1: begin
        fb_en   = need1;
        fb_addr = addr1;
      end
      ST_WR0: begin
        fb_en    = 1'b1;
        fb_we    = 1'b1;
        fb_addr  = addr0;
        fb_wdata = word0_q ^ mask0;
      end
      ST_WR1: begin
        fb_en    = need1;
        fb_we    = need1;
        fb_addr  = addr1;
        fb_wdata = word1_q ^ mask1;
      end
      ST_CLR: begin
        fb_en   = 1'b1;
        fb_we   = 1'b1;
        fb_addr = clr_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wide_q  <= 1'b0;
      clip_q  <= 1'b0;
      coll_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      nrows_q <= '0;
      row_q   <= '0;
      ptr_q   <= '0;
      pat_q   <= '0;
      word0_q <= '0;
      word1_q <= '0;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      wide_q  <= wide_d;
      clip_q  <= clip_d;
      coll_q  <= coll_d;
      x_q     <= x_d;
      y_q     <= y_d;
      nrows_q <= nrows_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      pat_q   <= pat_d;
      word0_q <= word0_d;
      word1_q <= word1_d;
      clr_q   <= clr_d;
    end
  end

endmodule

// File: tb/tb_sprite_blitter_gen.sv
// Bench for sprite_blitter_gen: pixel-level reference model against a behavioural framebuffer/CPU memory.
module tb_sprite_blitter_gen;

  localparam int WW  = 16;
  localparam int SW  = 128;
  localparam int SH  = 64;
  localparam int WPR = SW / WW;
  localparam int FBW = WPR * SH;

  logic        clk = 1'b0;
  logic        rst_n, start, op, clip;
  logic [11:0] src;
  logic [3:0]  height;
  logic [6:0]  dest_x;
  logic [5:0]  dest_y;
  logic        ready, collision, fb_en, fb_we;
  logic [8:0]  fb_addr;
  logic [15:0] fb_wdata, fb_rdata;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata;

  bit [15:0] fbm [FBW];
  bit [7:0]  cpu_mem [4096];
  bit        model_px [SH][SW];
  int        wr_cnt = 0;
  int        wr_log [$];
  int        checks = 0;
  int        passes = 0;
  int        fails  = 0;

  always #5 clk = ~clk;

  sprite_blitter_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .height(height),
    .dest_x(dest_x), .dest_y(dest_y), .clip(clip), .ready(ready), .collision(collision),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_rdata(fb_rdata), .fb_en(fb_en), .fb_we(fb_we),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (fb_en === 1'b1) begin
      if (fb_we) begin
        fbm[fb_addr] <= fb_wdata;
        wr_cnt <= wr_cnt + 1;
        wr_log.push_back(int'(fb_addr));
      end else begin
        fb_rdata <= fbm[fb_addr];
      end
    end
    mem_rdata <= cpu_mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit [15:0] model_word(input int i);
    bit [15:0] w;
    int y, wi;
    y = i / WPR;
    wi = i % WPR;
    for (int b = 0; b < WW; b++) w[WW-1-b] = model_px[y][wi*WW + b];
    return w;
  endfunction

  task automatic check_fb();
    for (int i = 0; i < FBW; i++) check($sformatf("fb[%0d]", i), fbm[i], model_word(i));
  endtask

  // Pixel-by-pixel XOR draw; a written word is any word holding at least one on-screen sprite column.
  task automatic model_sprite(input int s, input int h, input int x, input int y, input bit clp,
                              output int busy, output int nwr, output bit coll);
    int rows, pw, drawn, py, px;
    bit [15:0] pat;
    bit touched [WPR];
    rows = (h == 0) ? 16 : h;
    pw = (h == 0) ? 16 : 8;
    drawn = 0; nwr = 0; coll = 0;
    for (int r = 0; r < rows; r++) begin
      if (clp && (y + r >= SH)) break;
      py = (y + r) % SH;
      drawn++;
      if (h == 0) pat = {cpu_mem[(s + 2*r) % 4096], cpu_mem[(s + 2*r + 1) % 4096]};
      else        pat = {8'h00, cpu_mem[(s + r) % 4096]};
      for (int wi = 0; wi < WPR; wi++) touched[wi] = 0;
      for (int c = 0; c < pw; c++) begin
        px = x + c;
        if (clp && px >= SW) continue;
        px = px % SW;
        touched[px / WW] = 1;
        if (pat[pw-1-c]) begin
          if (model_px[py][px]) coll = 1;
          model_px[py][px] = !model_px[py][px];
        end
      end
      for (int wi = 0; wi < WPR; wi++) nwr += int'(touched[wi]);
    end
    busy = drawn * ((h == 0) ? 6 : 5) + 1;
  endtask

  task automatic run_cmd(input bit o, input int s, input int h, input int x, input int y, input bit clp,
                         input bit noise, output int busy, output int nwr, output int ls);
    int cyc;
    cyc = 0;
    while (!ready && cyc < 4000) begin @(posedge clk); #1; cyc++; end
    op = o; src = 12'(s); height = 4'(h); dest_x = 7'(x); dest_y = 6'(y); clip = clp;
    start = 1'b1;
    nwr = wr_cnt;
    ls = wr_log.size();
    @(posedge clk); #1;
    start = 1'b0;
    busy = 0;
    while (!ready && busy < 4000) begin
      if (noise) begin
        start = busy[0]; op = 1'b0; height = 4'($urandom);
        dest_x = 7'($urandom); dest_y = 6'($urandom); clip = 1'($urandom);
      end
      @(posedge clk); #1;
      busy++;
    end
    start = 1'b0;
    nwr = wr_cnt - nwr;
  endtask

  task automatic do_sprite(input int s, input int h, input int x, input int y, input bit clp);
    int busy, nwr, ls, eb, ew;
    bit ec;
    run_cmd(1'b0, s, h, x, y, clp, 1'b0, busy, nwr, ls);
    model_sprite(s, h, x, y, clp, eb, ew, ec);
    check("busy", busy, eb);
    check("writes", nwr, ew);
    check("collision", collision, ec);
    check_fb();
  endtask

  task automatic do_clear(input bit noise);
    int busy, nwr, ls;
    run_cmd(1'b1, 0, 1, 0, 0, 1'b0, noise, busy, nwr, ls);
    for (int yy = 0; yy < SH; yy++) for (int xx = 0; xx < SW; xx++) model_px[yy][xx] = 0;
    check("clr_busy", busy, FBW + 1);
    check("clr_writes", nwr, FBW);
    check("clr_collision", collision, 0);
    for (int k = 0; k < FBW && ls + k < wr_log.size(); k++) check("clr_order", wr_log[ls + k], k);
    check_fb();
  endtask

  initial begin
    int w0;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; src = '0; height = 4'd1;
    dest_x = '0; dest_y = '0; clip = 1'b0;
    for (int i = 0; i < 4096; i++) cpu_mem[i] = 8'($urandom);
    cpu_mem[12'h200] = 8'hF0;
    cpu_mem[12'h300] = 8'hFF;
    cpu_mem[12'h301] = 8'hFF;
    for (int i = 12'h400; i < 12'h420; i++) cpu_mem[i] = 8'hFF;

    #1;
    check("rst_ready", ready, 1);
    check("rst_collision", collision, 0);
    check("rst_fb_en", fb_en, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_mem_addr", mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_sprite(12'h200, 1, 0, 0, 1'b0);
    check("f0_word0", fbm[0], 16'hF000);
    do_sprite(12'h200, 1, 0, 0, 1'b0);
    check("f0_word0_again", fbm[0], 16'h0000);
    check("f0_collision", collision, 1);

    // Abort a sprite while it is reading the framebuffer.
    op = 1'b0; src = 12'h300; height = 4'd1; dest_x = 7'd0; dest_y = 6'd5; clip = 1'b0;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_collision", collision, 0);
    check("midrst_fb_en", fb_en, 0);
    check("midrst_fb_we", fb_we, 0);
    w0 = wr_cnt;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_writes", wr_cnt - w0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_fb();

    do_sprite(12'h300, 1, 12, 3, 1'b0);
    check("x12_word24", fbm[24], 16'h000F);
    check("x12_word25", fbm[25], 16'hF000);

    do_sprite(12'h300, 2, 124, 63, 1'b0);
    check("wrap_w511", fbm[511], 16'h000F);
    check("wrap_w504", fbm[504], 16'hF000);
    check("wrap_w7", fbm[7], 16'h000F);
    check("wrap_w0", fbm[0], 16'hF000);

    do_clear(1'b0);
    do_sprite(12'h300, 2, 124, 63, 1'b1);
    check("clip_w511", fbm[511], 16'h000F);
    check("clip_w504", fbm[504], 16'h0000);
    check("clip_w0", fbm[0], 16'h0000);

    do_clear(1'b0);
    do_sprite(12'h400, 0, 8, 0, 1'b0);
    for (int r = 0; r < 16; r++) begin
      check("wide_w0", fbm[8*r], 16'h00FF);
      check("wide_w1", fbm[8*r + 1], 16'hFF00);
    end

    for (int n = 0; n < 24; n++) begin
      int s;
      s = (n % 5 == 0) ? int'($urandom_range(4080, 4095)) : int'($urandom_range(0, 4095));
      do_sprite(s, int'($urandom_range(0, 15)), int'($urandom_range(0, SW-1)),
                int'($urandom_range(0, SH-1)), 1'($urandom_range(0, 1)));
    end

    do_clear(1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
